// File: rtl/rsa_stream_ctrl_if.sv
// Stream interface for rsa_stream_ctrl.
// Carries the message input handshake (in_valid/in_ready/in_data) and the
// result output handshake (out_valid/out_ready/out_data/out_err).
//   master : word source / result sink (drives in_*, out_ready)
//   slave  : the controller (accepts in_*, drives out_*, in_ready)
interface rsa_stream_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/rsa_stream_ctrl.sv
// Streaming front/back end for the modular exponentiation core.
// Holds a key pair, accepts one message word at a time, launches the
// exponentiator with a one-cycle set pulse, waits for finished (bounded by
// TIMEOUT), then presents the result until the downstream accepts it.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   key_load/exp/mod    : key register load (honoured only in IDLE)
//   strm (slave)        : message in / result out handshakes, out_err flag
//   exp_a/b/modulant    : registered operands to the exponentiator
//   exp_set             : one-cycle launch pulse
//   exp_out/finished    : exponentiator result and done flag
//   msg_count           : results delivered since reset (wraps)
module rsa_stream_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 2*DATA_WIDTH+4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  key_load,
    input  logic [DATA_WIDTH-1:0] key_exp,
    input  logic [DATA_WIDTH-1:0] key_mod,
    rsa_stream_ctrl_if.slave      strm,
    output logic [DATA_WIDTH-1:0] exp_a,
    output logic [DATA_WIDTH-1:0] exp_b,
    output logic [DATA_WIDTH-1:0] exp_modulant,
    output logic                  exp_set,
    input  logic [DATA_WIDTH-1:0] exp_out,
    input  logic                  exp_finished,
    output logic [15:0]           msg_count
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] key_exp_r, key_mod_r, msg_r, res_data;
    logic                  res_err;
    logic [TW-1:0]         tcnt;
    logic                  in_ready_i, accept, reject, timed_out;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready_i = 1'b0;
        exp_set    = 1'b0;
        accept     = 1'b0;
        // key_load takes the slot: input is not accepted in a key-load cycle
        in_ready_i = (state == S_IDLE) && !key_load;
        accept     = strm.in_valid && in_ready_i;
        reject     = (key_mod_r < DATA_WIDTH'(2)) || (strm.in_data >= key_mod_r);
        timed_out  = (tcnt == TW'(TIMEOUT-1));
        case (state)
            S_IDLE:   if (accept) state_next = reject ? S_HOLD : S_LAUNCH;
            S_LAUNCH: begin
                exp_set    = 1'b1;
                state_next = S_WAIT;
            end
            // finished has priority over the timeout in the same cycle
            S_WAIT:   if (exp_finished || timed_out) state_next = S_HOLD;
            S_HOLD:   if (strm.out_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_exp_r <= '0;
            key_mod_r <= '0;
            msg_r     <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            tcnt      <= '0;
            msg_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (key_load) begin
                        key_exp_r <= key_exp;
                        key_mod_r <= key_mod;
                    end
                    if (accept) begin
                        if (reject) begin
                            res_data <= '0;
                            res_err  <= 1'b1;
                        end else begin
                            msg_r <= strm.in_data;
                        end
                    end
                end
                S_LAUNCH: tcnt <= '0;
                S_WAIT: begin
                    if (exp_finished) begin
                        res_data <= exp_out;
                        res_err  <= 1'b0;
                    end else if (timed_out) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_HOLD: if (strm.out_ready) msg_count <= msg_count + 16'd1;
                default: ;
            endcase
        end
    end

    assign strm.in_ready  = in_ready_i;
    assign strm.out_valid = (state == S_HOLD);
    assign strm.out_data  = res_data;
    assign strm.out_err   = res_err;
    assign exp_a          = msg_r;
    assign exp_b          = key_exp_r;
    assign exp_modulant   = key_mod_r;
endmodule

// File: tb/tb_rsa_stream_ctrl.sv
module tb_rsa_stream_ctrl;
    localparam int DW      = 8;
    localparam int TIMEOUT = 2*DW+4;
    localparam int LAT     = DW+1;

    logic          clock = 1'b0;
    logic          reset;
    logic          key_load;
    logic [DW-1:0] key_exp, key_mod;
    logic [DW-1:0] exp_a, exp_b, exp_modulant, exp_out;
    logic          exp_set, exp_finished;
    logic [15:0]   msg_count;

    rsa_stream_ctrl_if #(.DATA_WIDTH(DW)) strm();

    rsa_stream_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .key_load(key_load), .key_exp(key_exp),
        .key_mod(key_mod), .strm(strm), .exp_a(exp_a), .exp_b(exp_b),
        .exp_modulant(exp_modulant), .exp_set(exp_set), .exp_out(exp_out),
        .exp_finished(exp_finished), .msg_count(msg_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int set_pulses = 0;
    int exp_count = 0;
    bit core_hang = 1'b0;

    function automatic int modexp(int a, int b, int m);
        int r;
        if (m == 0) return 0;
        r = 1 % m;
        for (int i = 0; i < b; i++) r = (r * a) % m;
        return r;
    endfunction

    // Exponentiator stand-in: fixed latency, finished stays high until next set.
    int            core_cnt;
    bit            core_busy;
    logic [DW-1:0] core_res;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            core_busy <= 1'b0; core_cnt <= 0; exp_finished <= 1'b0; exp_out <= '0; core_res <= '0;
        end else if (exp_set) begin
            core_busy <= 1'b1; core_cnt <= 0; exp_finished <= 1'b0;
            exp_out <= DW'($urandom);
            core_res <= DW'(modexp(int'(exp_a), int'(exp_b), int'(exp_modulant)));
        end else if (core_busy && !core_hang) begin
            if (core_cnt == LAT-1) begin
                exp_finished <= 1'b1; exp_out <= core_res; core_busy <= 1'b0;
            end else core_cnt <= core_cnt + 1;
        end
    end

    always @(negedge clock) if (exp_set === 1'b1) set_pulses++;

    task automatic load_key(input int e, input int m);
        @(negedge clock);
        key_load = 1'b1; key_exp = DW'(e); key_mod = DW'(m);
        @(posedge clock);
        #1 key_load = 1'b0;
    endtask

    task automatic send(input int d, output bit ok);
        ok = 1'b0;
        @(negedge clock);
        strm.in_valid = 1'b1; strm.in_data = DW'(d);
        for (int i = 0; i < 200; i++) begin
            #1;
            if (strm.in_ready === 1'b1) begin
                @(posedge clock);
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        #1 strm.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok, output int n);
        ok = 1'b0; n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            n++;
            if (strm.out_valid === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic take();
        strm.out_ready = 1'b1;
        @(posedge clock);
        #1 strm.out_ready = 1'b0;
        exp_count = (exp_count + 1) % 65536;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (strm.out_valid !== 1'b0 || strm.out_err !== 1'b0 || exp_set !== 1'b0) begin
            errors++; $display("FAIL reset_flags: valid=%b err=%b set=%b want 0 0 0", strm.out_valid, strm.out_err, exp_set); end
        checks++; if (exp_a !== '0 || exp_b !== '0 || exp_modulant !== '0 || strm.out_data !== '0) begin
            errors++; $display("FAIL reset_regs: a=%0d b=%0d m=%0d data=%0d want all 0", exp_a, exp_b, exp_modulant, strm.out_data); end
        checks++; if (msg_count !== 16'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", msg_count); end
        @(negedge clock); reset = 1'b0; #1;
        checks++; if (strm.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", strm.in_ready); end
    endtask

    task automatic test_encrypt();
        bit ok; int n, p;
        p = set_pulses;
        @(negedge clock);
        key_load = 1'b1; key_exp = 8'd3; key_mod = 8'd33; strm.in_valid = 1'b1; strm.in_data = 8'd4;
        #1;
        checks++; if (strm.in_ready !== 1'b0) begin
            errors++; $display("FAIL keyload_priority: in_ready=%b want 0", strm.in_ready); end
        @(posedge clock); #1 key_load = 1'b0; strm.in_valid = 1'b0;
        @(negedge clock);
        checks++; if (exp_b !== 8'd3 || exp_modulant !== 8'd33 || set_pulses != p || strm.out_valid !== 1'b0) begin
            errors++; $display("FAIL keyload_capture: b=%0d m=%0d pulses=%0d valid=%b want 3 33 0 0", exp_b, exp_modulant, set_pulses-p, strm.out_valid); end
        send(4, ok);
        wait_valid(ok, n);
        checks++; if (!ok) begin errors++; $display("FAIL encrypt_valid: out_valid never rose"); end
        checks++; if (strm.out_data !== 8'd31 || strm.out_err !== 1'b0 || set_pulses - p != 1) begin
            errors++; $display("FAIL encrypt_result: data=%0d err=%b pulses=%0d want 31 0 1", strm.out_data, strm.out_err, set_pulses-p); end
        take();
        @(negedge clock);
        checks++; if (msg_count !== 16'(exp_count) || strm.out_valid !== 1'b0) begin
            errors++; $display("FAIL encrypt_count: count=%0d valid=%b want %0d 0", msg_count, strm.out_valid, exp_count); end
    endtask

    task automatic test_reject();
        bit ok; int n, p;
        p = set_pulses;
        send(40, ok);
        wait_valid(ok, n);
        checks++; if (!ok || n != 1) begin errors++; $display("FAIL reject_latency: ok=%b n=%0d want 1 1", ok, n); end
        checks++; if (strm.out_data !== 8'd0 || strm.out_err !== 1'b1 || set_pulses != p) begin
            errors++; $display("FAIL reject_range: data=%0d err=%b pulses=%0d want 0 1 0", strm.out_data, strm.out_err, set_pulses-p); end
        take();
        load_key(3, 1);
        send(0, ok);
        wait_valid(ok, n);
        checks++; if (!ok || strm.out_err !== 1'b1 || strm.out_data !== 8'd0 || set_pulses != p) begin
            errors++; $display("FAIL reject_mod1: ok=%b err=%b data=%0d pulses=%0d want 1 1 0 0", ok, strm.out_err, strm.out_data, set_pulses-p); end
        take();
        @(negedge clock);
        checks++; if (msg_count !== 16'(exp_count)) begin
            errors++; $display("FAIL reject_count: got %0d want %0d", msg_count, exp_count); end
    endtask

    task automatic test_backpressure();
        bit ok; int n, p;
        load_key(3, 33);
        send(4, ok);
        wait_valid(ok, n);
        strm.in_valid = 1'b1; strm.in_data = 8'd7;
        p = set_pulses;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (strm.out_valid !== 1'b1 || strm.out_data !== 8'd31 || strm.in_ready !== 1'b0) begin
                errors++; $display("FAIL hold_stable: cyc=%0d valid=%b data=%0d in_ready=%b want 1 31 0", i, strm.out_valid, strm.out_data, strm.in_ready); end
            @(negedge clock);
        end
        checks++; if (set_pulses != p) begin errors++; $display("FAIL hold_no_launch: pulses=%0d want 0", set_pulses-p); end
        take();
        @(posedge clock); #1 strm.in_valid = 1'b0;
        wait_valid(ok, n);
        checks++; if (!ok || strm.out_data !== DW'(modexp(7, 3, 33)) || strm.out_err !== 1'b0 || set_pulses - p != 1) begin
            errors++; $display("FAIL second_msg: ok=%b data=%0d err=%b pulses=%0d want 1 %0d 0 1", ok, strm.out_data, strm.out_err, set_pulses-p, modexp(7, 3, 33)); end
        take();
        @(negedge clock);
        checks++; if (msg_count !== 16'(exp_count)) begin
            errors++; $display("FAIL bp_count: got %0d want %0d", msg_count, exp_count); end
    endtask

    task automatic test_exp_zero_keygate();
        bit ok; int n;
        load_key(0, 33);
        send(5, ok);
        wait_valid(ok, n);
        checks++; if (!ok || strm.out_data !== 8'd1 || strm.out_err !== 1'b0) begin
            errors++; $display("FAIL exp_zero: ok=%b data=%0d err=%b want 1 1 0", ok, strm.out_data, strm.out_err); end
        take();
        send(6, ok);
        repeat (3) @(negedge clock);
        key_load = 1'b1; key_exp = 8'd7; key_mod = 8'd50;
        @(posedge clock); #1 key_load = 1'b0;
        checks++; if (exp_b !== 8'd0 || exp_modulant !== 8'd33 || exp_a !== 8'd6) begin
            errors++; $display("FAIL keygate_regs: a=%0d b=%0d m=%0d want 6 0 33", exp_a, exp_b, exp_modulant); end
        wait_valid(ok, n);
        checks++; if (!ok || strm.out_data !== 8'd1) begin
            errors++; $display("FAIL keygate_result: ok=%b data=%0d want 1 1", ok, strm.out_data); end
        take();
        send(2, ok);
        wait_valid(ok, n);
        checks++; if (!ok || strm.out_data !== 8'd1) begin
            errors++; $display("FAIL keygate_next: ok=%b data=%0d want 1 1", ok, strm.out_data); end
        take();
    endtask

    task automatic test_timeout();
        bit ok; int n;
        load_key(3, 33);
        core_hang = 1'b1;
        send(4, ok);
        wait_valid(ok, n);
        checks++; if (!ok || n != TIMEOUT+2) begin
            errors++; $display("FAIL timeout_latency: ok=%b n=%0d want 1 %0d", ok, n, TIMEOUT+2); end
        checks++; if (strm.out_data !== 8'd0 || strm.out_err !== 1'b1) begin
            errors++; $display("FAIL timeout_result: data=%0d err=%b want 0 1", strm.out_data, strm.out_err); end
        core_hang = 1'b0;
        take();
    endtask

    task automatic test_async_reset();
        bit ok; int n;
        load_key(3, 33);
        send(4, ok);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        exp_count = 0;
        checks++; if (strm.out_valid !== 1'b0 || strm.in_ready !== 1'b1 || exp_set !== 1'b0) begin
            errors++; $display("FAIL areset_flags: valid=%b in_ready=%b set=%b want 0 1 0", strm.out_valid, strm.in_ready, exp_set); end
        checks++; if (msg_count !== 16'd0 || exp_b !== '0 || exp_modulant !== '0) begin
            errors++; $display("FAIL areset_regs: count=%0d b=%0d m=%0d want 0 0 0", msg_count, exp_b, exp_modulant); end
        @(negedge clock); reset = 1'b0;
        load_key(3, 33);
        send(4, ok);
        wait_valid(ok, n);
        checks++; if (!ok || strm.out_data !== 8'd31 || strm.out_err !== 1'b0) begin
            errors++; $display("FAIL areset_resume: ok=%b data=%0d err=%b want 1 31 0", ok, strm.out_data, strm.out_err); end
        take();
        @(negedge clock);
        checks++; if (msg_count !== 16'(exp_count)) begin
            errors++; $display("FAIL areset_count: got %0d want %0d", msg_count, exp_count); end
    endtask

    task automatic test_random();
        bit ok, hang, rej; int n, p, e, m, d, want_data, want_err;
        for (int it = 0; it < 40; it++) begin
            e = $urandom_range(0, 15);
            m = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(2, 255);
            d = ($urandom_range(0, 3) == 0 || m == 0) ? $urandom_range(0, 255) : $urandom_range(0, m-1);
            hang = ($urandom_range(0, 7) == 0);
            rej = (m < 2) || (d >= m);
            want_err  = (rej || hang) ? 1 : 0;
            want_data = want_err ? 0 : modexp(d, e, m);
            load_key(e, m);
            core_hang = hang;
            p = set_pulses;
            send(d, ok);
            wait_valid(ok, n);
            repeat ($urandom_range(0, 3)) @(negedge clock);
            checks++; if (!ok || strm.out_valid !== 1'b1 || strm.out_data !== DW'(want_data) || strm.out_err !== want_err[0] || set_pulses - p != (rej ? 0 : 1)) begin
                errors++; $display("FAIL random[%0d] e=%0d m=%0d d=%0d: data=%0d err=%b pulses=%0d want %0d %0d %0d", it, e, m, d, strm.out_data, strm.out_err, set_pulses-p, want_data, want_err, rej ? 0 : 1); end
            core_hang = 1'b0;
            take();
        end
        @(negedge clock);
        checks++; if (msg_count !== 16'(exp_count)) begin
            errors++; $display("FAIL random_count: got %0d want %0d", msg_count, exp_count); end
    endtask

    initial begin
        reset = 1'b1; key_load = 1'b0; key_exp = '0; key_mod = '0;
        strm.in_valid = 1'b0; strm.in_data = '0; strm.out_ready = 1'b0;
        test_reset();
        test_encrypt();
        test_reject();
        test_backpressure();
        test_exp_zero_keygate();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
